// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: decimates an RGB565 pixel stream, converts it to RGB444 and writes it
// into a ping-pong frame buffer. Complete frames swap banks when the display is not locked.
module frame_buffer_writer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              p_clock,
    input  logic              rst_n,
    input  logic [15:0]       pixel_data,
    input  logic              pixel_valid,
    input  logic              frame_done,
    input  logic              rd_lock,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              rd_bank,
    output logic              frame_ready,
    output logic              err_short,
    output logic              err_long,
    output logic [7:0]        drop_count
);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
    localparam logic [XW-1:0] X_MASK = XW'((1 << SCALE_SHIFT) - 1);
    localparam logic [YW-1:0] Y_MASK = YW'((1 << SCALE_SHIFT) - 1);
    localparam logic [1:0] SYNC = 2'd0, CAPTURE = 2'd1, PENDING = 2'd2, SKIP = 2'd3;

    logic [1:0]        state, state_n;
    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              overflow, overflow_n, early;
    logic              accept, write, complete, swap, drop, clear, ending;
    logic              unused_bits;

    assign unused_bits = ^{pixel_data[11], pixel_data[6:5], pixel_data[0]};
    assign rd_bank = ~wr_bank;

    // y == Y_END means every line is consumed; any further pixel is an overflow
    always_comb begin
        accept     = state == CAPTURE && pixel_valid && !overflow;
        write      = accept && y != Y_END && (x & X_MASK) == '0 && (y & Y_MASK) == '0;
        x_n        = (accept && y != Y_END) ? (x == X_LAST ? '0 : x + 1'b1) : x;
        y_n        = (accept && y != Y_END && x == X_LAST) ? y + 1'b1 : y;
        overflow_n = overflow || (accept && y == Y_END);
        addr_n     = write ? addr + 1'b1 : addr;
        complete   = x_n == '0 && y_n == Y_END && !overflow_n;
        ending     = state == CAPTURE && frame_done;
        swap       = state == PENDING && !rd_lock;
        drop       = (ending && !complete) || (swap && (early || pixel_valid));
        clear      = (frame_done && state != PENDING) || swap;
        state_n    = state == SYNC    ? (frame_done ? CAPTURE : SYNC)
                   : state == CAPTURE ? (ending && complete ? PENDING : CAPTURE)
                   : state == PENDING ? (swap ? ((early || pixel_valid) ? SKIP : CAPTURE) : PENDING)
                   : (frame_done ? CAPTURE : SKIP);
    end

    always_ff @(posedge p_clock) begin
        if (!rst_n) begin
            state       <= SYNC;
            x           <= '0;
            y           <= '0;
            addr        <= '0;
            overflow    <= 1'b0;
            early       <= 1'b0;
            wr_en       <= 1'b0;
            wr_bank     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_ready <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            drop_count  <= '0;
        end else begin
            state       <= state_n;
            x           <= clear ? '0 : x_n;
            y           <= clear ? '0 : y_n;
            addr        <= clear ? '0 : addr_n;
            overflow    <= clear ? 1'b0 : overflow_n;
            early       <= state == PENDING && !swap && (early || pixel_valid);
            wr_en       <= write;
            frame_ready <= swap;
            err_short   <= ending && !complete && !overflow_n;
            err_long    <= ending && overflow_n;
            if (write) begin
                wr_addr <= addr;
                wr_data <= {pixel_data[15:12], pixel_data[10:7], pixel_data[4:1]};
            end
            if (swap)
                wr_bank <= ~wr_bank;
            if (drop && drop_count != 8'hff)
                drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: directed scenarios for frame_buffer_writer at 8x4 pixels, 2:1 decimation.
module tb_frame_buffer_writer;
    logic        p_clock = 1'b0, rst_n = 1'b0, pixel_valid = 1'b0, frame_done = 1'b0, rd_lock = 1'b0;
    logic [15:0] pixel_data = '0;
    logic        wr_en, wr_bank, rd_bank, frame_ready, err_short, err_long;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic [7:0]  drop_count;

    int checks = 0, failures = 0;
    int n_ready = 0, n_short = 0, n_long = 0;
    logic        wb_q[$];
    logic [2:0]  wa_q[$];
    logic [11:0] wd_q[$];
    logic [63:0] seen_en;
    logic [11:0] idx_data [8] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd8, 12'd9, 12'd10, 12'd11};

    frame_buffer_writer #(.H_ACTIVE(8), .V_ACTIVE(4), .SCALE_SHIFT(1), .ADDR_W(3)) dut (
        .p_clock(p_clock), .rst_n(rst_n), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .frame_done(frame_done), .rd_lock(rd_lock), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_bank(rd_bank), .frame_ready(frame_ready),
        .err_short(err_short), .err_long(err_long), .drop_count(drop_count)
    );

    always #5 p_clock = ~p_clock;

    always @(negedge p_clock) begin
        if (wr_en) begin
            wb_q.push_back(wr_bank);
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (frame_ready) n_ready++;
        if (err_short) n_short++;
        if (err_long) n_long++;
    end

    function automatic logic [15:0] pix(input int i, input bit color);
        if (!color) return 16'(i);
        return ((i / 8) % 4 >= 2) ? 16'h5A3C : 16'hA5C3;
    endfunction

    task automatic tick();
        @(posedge p_clock);
        #1;
    endtask

    task automatic clear_log();
        wb_q.delete();
        wa_q.delete();
        wd_q.delete();
        n_ready = 0;
        n_short = 0;
        n_long = 0;
        seen_en = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic drive_pixels(input int start, input int n, input bit color);
        for (int i = start; i < start + n; i++) begin
            pixel_valid = 1'b1;
            pixel_data = pix(i, color);
            tick();
            if (i < 64) seen_en[i] = wr_en;
        end
        pixel_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit coincide, input bit color);
        if (coincide) begin
            drive_pixels(0, n - 1, color);
            pixel_valid = 1'b1;
            pixel_data = pix(n - 1, color);
            frame_done = 1'b1;
            tick();
            seen_en[n-1] = wr_en;
            pixel_valid = 1'b0;
            frame_done = 1'b0;
        end else begin
            drive_pixels(0, n, color);
            pulse_fd();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({wr_en, wr_addr, wr_data} !== 16'h0) begin
            failures++;
            $display("FAIL reset_wr got en=%b addr=%0d data=%h want 0/0/000", wr_en, wr_addr, wr_data);
        end
        checks++;
        if ({wr_bank, rd_bank} !== 2'b01) begin
            failures++;
            $display("FAIL reset_bank got wr=%b rd=%b want wr=0 rd=1", wr_bank, rd_bank);
        end
        checks++;
        if ({frame_ready, err_short, err_long, drop_count} !== 11'h0) begin
            failures++;
            $display("FAIL reset_status got rdy=%b es=%b el=%b drop=%0d want all 0",
                     frame_ready, err_short, err_long, drop_count);
        end
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic test_basic();
        do_reset();
        pulse_fd();
        send_frame(32, 0, 0);
        checks++;
        if (seen_en[31:0] !== 32'h0055_0055) begin
            failures++;
            $display("FAIL basic_latency got wr_en pattern %h want 00550055", seen_en[31:0]);
        end
        checks++;
        if (wa_q.size() != 8) begin
            failures++;
            $display("FAIL basic_count got %0d writes want 8", wa_q.size());
        end
        for (int k = 0; k < 8 && k < wa_q.size(); k++) begin
            checks++;
            if ({wb_q[k], wa_q[k], wd_q[k]} !== {1'b0, 3'(k), idx_data[k]}) begin
                failures++;
                $display("FAIL basic_write%0d got bank=%b addr=%0d data=%h want bank=0 addr=%0d data=%h",
                         k, wb_q[k], wa_q[k], wd_q[k], k, idx_data[k]);
            end
        end
        tick();
        checks++;
        if ({frame_ready, wr_bank, rd_bank} !== 3'b110) begin
            failures++;
            $display("FAIL basic_swap got rdy=%b wr=%b rd=%b want 1/1/0", frame_ready, wr_bank, rd_bank);
        end
        tick();
        checks++;
        if ({frame_ready, n_ready, n_short, n_long} !== {1'b0, 32'd1, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL basic_pulse got rdy=%b n_ready=%0d es=%0d el=%0d want 0/1/0/0",
                     frame_ready, n_ready, n_short, n_long);
        end
    endtask

    task automatic test_sync();
        do_reset();
        drive_pixels(0, 20, 0);
        checks++;
        if (wa_q.size() != 0) begin
            failures++;
            $display("FAIL sync_discard got %0d writes want 0", wa_q.size());
        end
        pulse_fd();
        send_frame(32, 0, 1);
        checks++;
        if (wa_q.size() != 8) begin
            failures++;
            $display("FAIL sync_count got %0d writes want 8", wa_q.size());
        end
        for (int k = 0; k < 8 && k < wa_q.size(); k++) begin
            checks++;
            if ({wa_q[k], wd_q[k]} !== {3'(k), (k < 4) ? 12'hAB1 : 12'h54E}) begin
                failures++;
                $display("FAIL sync_color%0d got addr=%0d data=%h want addr=%0d data=%h",
                         k, wa_q[k], wd_q[k], k, (k < 4) ? 12'hAB1 : 12'h54E);
            end
        end
        tick();
        checks++;
        if ({frame_ready, wr_bank} !== 2'b11) begin
            failures++;
            $display("FAIL sync_swap got rdy=%b wr=%b want 1/1", frame_ready, wr_bank);
        end
    endtask

    task automatic test_short();
        do_reset();
        pulse_fd();
        send_frame(31, 0, 0);
        checks++;
        if ({err_short, err_long, drop_count} !== {2'b10, 8'd1}) begin
            failures++;
            $display("FAIL short_err got es=%b el=%b drop=%0d want 1/0/1", err_short, err_long, drop_count);
        end
        checks++;
        if (wa_q.size() != 8) begin
            failures++;
            $display("FAIL short_count got %0d writes want 8", wa_q.size());
        end
        tick();
        checks++;
        if ({err_short, wr_bank, n_ready} !== {2'b00, 32'd0}) begin
            failures++;
            $display("FAIL short_nobank got es=%b wr=%b n_ready=%0d want 0/0/0", err_short, wr_bank, n_ready);
        end
        clear_log();
        send_frame(32, 0, 0);
        checks++;
        if (wa_q.size() != 8 || {wa_q[0], wa_q[7], wb_q[7]} !== {3'd0, 3'd7, 1'b0}) begin
            failures++;
            $display("FAIL short_next got n=%0d first=%0d last=%0d want 8 writes 0..7 bank 0",
                     wa_q.size(), wa_q[0], wa_q[7]);
        end
        tick();
        checks++;
        if ({frame_ready, wr_bank} !== 2'b11) begin
            failures++;
            $display("FAIL short_swap got rdy=%b wr=%b want 1/1", frame_ready, wr_bank);
        end
    endtask

    task automatic test_long();
        do_reset();
        pulse_fd();
        send_frame(33, 0, 0);
        checks++;
        if (seen_en[32] !== 1'b0 || wa_q.size() != 8) begin
            failures++;
            $display("FAIL long_extra got en33=%b writes=%0d want 0/8", seen_en[32], wa_q.size());
        end
        checks++;
        if ({err_short, err_long, drop_count} !== {2'b01, 8'd1}) begin
            failures++;
            $display("FAIL long_err got es=%b el=%b drop=%0d want 0/1/1", err_short, err_long, drop_count);
        end
        repeat (3) tick();
        checks++;
        if ({wr_bank, n_ready} !== {1'b0, 32'd0}) begin
            failures++;
            $display("FAIL long_noswap got wr=%b n_ready=%0d want 0/0", wr_bank, n_ready);
        end
    endtask

    task automatic test_lock();
        do_reset();
        pulse_fd();
        rd_lock = 1'b1;
        send_frame(32, 0, 0);
        drive_pixels(0, 10, 0);
        repeat (30) tick();
        checks++;
        if ({wr_bank, n_ready, wa_q.size()} !== {1'b0, 32'd0, 32'd8}) begin
            failures++;
            $display("FAIL lock_hold got wr=%b n_ready=%0d writes=%0d want 0/0/8", wr_bank, n_ready, wa_q.size());
        end
        rd_lock = 1'b0;
        tick();
        checks++;
        if ({frame_ready, wr_bank, rd_bank, drop_count} !== {3'b110, 8'd1}) begin
            failures++;
            $display("FAIL lock_release got rdy=%b wr=%b rd=%b drop=%0d want 1/1/0/1",
                     frame_ready, wr_bank, rd_bank, drop_count);
        end
        drive_pixels(10, 22, 0);
        pulse_fd();
        checks++;
        if ({wa_q.size(), n_ready} !== {32'd8, 32'd1}) begin
            failures++;
            $display("FAIL lock_skip got writes=%0d n_ready=%0d want 8/1", wa_q.size(), n_ready);
        end
        clear_log();
        send_frame(32, 0, 0);
        checks++;
        if (wa_q.size() != 8 || {wb_q[0], wb_q[7], wa_q[7], wd_q[7]} !== {2'b11, 3'd7, 12'd11}) begin
            failures++;
            $display("FAIL lock_newbank got n=%0d bank0=%b bank7=%b addr7=%0d data7=%h want 8/1/1/7/00b",
                     wa_q.size(), wb_q[0], wb_q[7], wa_q[7], wd_q[7]);
        end
        tick();
        checks++;
        if ({frame_ready, wr_bank} !== 2'b10) begin
            failures++;
            $display("FAIL lock_swapback got rdy=%b wr=%b want 1/0", frame_ready, wr_bank);
        end
    endtask

    task automatic test_coincide_reset();
        do_reset();
        pulse_fd();
        send_frame(32, 1, 0);
        checks++;
        if (wa_q.size() != 8 || wd_q[7] !== 12'd11) begin
            failures++;
            $display("FAIL coin_writes got n=%0d data7=%h want 8/00b", wa_q.size(), wd_q[7]);
        end
        tick();
        checks++;
        if ({frame_ready, wr_bank, n_short, n_long} !== {2'b11, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL coin_swap got rdy=%b wr=%b es=%0d el=%0d want 1/1/0/0",
                     frame_ready, wr_bank, n_short, n_long);
        end
        drive_pixels(0, 12, 0);
        checks++;
        if ({wr_addr, wr_data} !== {3'd3, 12'd3}) begin
            failures++;
            $display("FAIL midframe_state got addr=%0d data=%h want 3/003", wr_addr, wr_data);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_ready, drop_count} !== {1'b0, 3'd0, 12'd0, 3'b010, 8'd0}) begin
            failures++;
            $display("FAIL midreset got en=%b addr=%0d data=%h wr=%b rd=%b rdy=%b drop=%0d want 0/0/000/0/1/0/0",
                     wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_ready, drop_count);
        end
        rst_n = 1'b1;
        clear_log();
        drive_pixels(12, 20, 0);
        pulse_fd();
        repeat (3) tick();
        checks++;
        if ({wa_q.size(), n_ready, wr_bank} !== {32'd0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_resync got writes=%0d n_ready=%0d wr=%b want 0/0/0",
                     wa_q.size(), n_ready, wr_bank);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sync();
        test_short();
        test_long();
        test_lock();
        test_coincide_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_buffer_writer.md
# frame_buffer_writer

Downstream of the camera capture stage. Takes its 16-bit RGB565 pixel stream (`pixel_data`/`pixel_valid`) and end-of-frame pulse (`frame_done`), optionally decimates 2^S:1 in both axes, and converts to RGB444. It writes the result into a ping-pong (two-bank) BRAM frame buffer. Complete frames are handed to the display side by a tear-free bank swap; malformed frames are discarded and flagged.

## Interface
- `H_ACTIVE`, 640: camera pixels per line.
- `V_ACTIVE`, 480: camera lines per frame.
- `SCALE_SHIFT`, 1: decimation exponent S (0 = full resolution, 1 = keep every 2nd pixel and every 2nd line).
- `ADDR_W`, 17: per-bank write address width. Must satisfy 2^ADDR_W ≥ (H_ACTIVE>>S)*(V_ACTIVE>>S).
- `p_clock` in 1: pixel clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `pixel_data` in 16: RGB565 pixel, valid when `pixel_valid`=1.
- `pixel_valid` in 1: one-cycle strobe per pixel.
- `frame_done` in 1: one-cycle pulse marking end of frame.
- `rd_lock` in 1: high while the display is scanning `rd_bank`; bank swap is forbidden while it is high.
- `wr_en` out 1: BRAM write strobe.
- `wr_bank` out 1: bank being written.
- `wr_addr` out ADDR_W: write address within `wr_bank`.
- `wr_data` out 12: RGB444 = {p[15:12], p[10:7], p[4:1]}.
- `rd_bank` out 1: bank holding the newest complete frame; always equals ~`wr_bank`.
- `frame_ready` out 1: one-cycle pulse when a swap occurs.
- `err_short` out 1: one-cycle pulse; frame ended with fewer than H_ACTIVE*V_ACTIVE pixels.
- `err_long` out 1: one-cycle pulse; frame exceeded H_ACTIVE*V_ACTIVE pixels.
- `drop_count` out 8: saturating count of discarded or skipped frames.

## Operation
- Counters: `x` (0..H_ACTIVE-1) and `y` (0..V_ACTIVE-1) advance per accepted `pixel_valid`. `x` wraps to 0 and increments `y`. A pixel arriving with x=H_ACTIVE-1, y=V_ACTIVE-1 already consumed sets an internal `overflow` flag. No writes occur while `overflow`=1.
- Keep rule: a pixel is written iff x[S-1:0]==0 and y[S-1:0]==0; with S=0, every pixel is written. A running address counter starts at 0 each frame and increments after each kept pixel. Kept pixels therefore occupy addresses 0..(H>>S)*(V>>S)-1 in raster order.
- A frame is complete iff, at `frame_done`, x==0, y==V_ACTIVE (all lines consumed), and `overflow`=0.
- States:
  - SYNC: reset state. Discard all pixels. On `frame_done`, go to CAPTURE with counters cleared. This guarantees frame alignment.
  - CAPTURE: write kept pixels. On `frame_done`:
    - Complete: go to PENDING.
    - Short: pulse `err_short`, increment `drop_count`, clear counters, stay in CAPTURE on the same bank.
    - Overflow: pulse `err_long`, increment `drop_count`, clear counters, stay in CAPTURE on the same bank.
  - PENDING: no writes. Set internal `early` if any `pixel_valid` arrives. When `rd_lock`=0:
    - Toggle `wr_bank`/`rd_bank` and pulse `frame_ready`.
    - Clear counters.
    - Go to CAPTURE if `early`=0. Otherwise go to SKIP and increment `drop_count`.
  - SKIP: discard pixels until `frame_done`, then go to CAPTURE with counters cleared.
- Simultaneous `pixel_valid` and `frame_done` in CAPTURE: the pixel is counted (and written if kept) as part of the ending frame, then the completeness check uses the updated counters.
- Swap in the same cycle that PENDING is entered is not allowed. The earliest swap is the cycle after the `frame_done` that entered PENDING.
- `drop_count` saturates at 255 and is cleared only by reset.

## Timing
- Reset (`rst_n`=0 at an edge) values:
  - state=SYNC
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_bank`=0, `rd_bank`=1
  - `frame_ready`=0, `err_short`=0, `err_long`=0, `drop_count`=0
  - all counters and flags 0
- Reset mid-frame abandons the partial frame. No swap occurs; the writer resynchronises via SYNC.
- Write latency: `wr_en`/`wr_addr`/`wr_data`/`wr_bank` are registered. They are valid exactly 1 cycle after the `pixel_valid` edge, and `wr_en` is high for 1 cycle.
- `err_short`/`err_long` are asserted the cycle after the `frame_done` edge.
- `frame_ready` and the bank toggle are asserted the cycle after the edge at which PENDING samples `rd_lock`=0. Both change in the same cycle. `wr_bank` never changes while `wr_en`=1.

## Test plan
Bench parameters: H_ACTIVE=8, V_ACTIVE=4, S=1, ADDR_W=3.

1. Reset, one `frame_done`, then a 32-pixel frame with data=index and `frame_done`, with `rd_lock`=0.
   - Exactly 8 writes at addr 0..7 from pixels 0,2,4,6,16,18,20,22, each RGB444-converted.
   - `frame_ready` pulse; `wr_bank` goes 0→1 and `rd_bank` goes 1→0.
2. Pixels before the first `frame_done` after reset → no `wr_en` at all. Then a normal frame → writes as in scenario 1.
3. A 31-pixel frame → 8 writes (last line incomplete), then `err_short` pulse, `drop_count`=1, no bank change. The next full frame swaps normally.
4. A 33-pixel frame → the 33rd pixel is not written, then `err_long` pulse, `drop_count`=1, no swap.
5. `rd_lock`=1 across `frame_done`, held 40 cycles while the next frame's pixels start; then `rd_lock`=0.
   - Swap and `frame_ready` occur the cycle after `rd_lock` falls.
   - State goes to SKIP and `drop_count`=1.
   - The following frame is written into the new `wr_bank`.
6. The last pixel coincides with `frame_done` → the frame is judged complete and swaps. Separately, a reset asserted mid-frame → all outputs return to their reset values and no swap occurs.
